apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parametrised APB memory-mapped slave: the next-generation replacement for the fixed 8-bit, 64-entry, zero-wait slaves on the APB bus. It adds:
- configurable data width, depth and wait states;
- byte-lane write strobes;
- error response on out-of-range addresses;
- fully registered handshake outputs.

It sits behind the APB master/decoder, one instance per PSEL line.

## Interface
- DATA_W, 32, data bus width; multiple of 8, at least 8.
- ADDR_W, 8, address bus width; PADDR is a word index, not a byte address.
- DEPTH, 64, number of DATA_W-bit words; DEPTH ≤ 2^ADDR_W.
- WAIT_STATES, 1, access-phase cycles with PREADY low before completion; range 0..15.
- PCLK  input  1  bus clock; everything is on its rising edge.
- PRST  input  1  asynchronous, active-low reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_W  word address.
- PWDATA  input  DATA_W  write data.
- PSTRB  input  DATA_W/8  byte-lane write enables; ignored on reads.
- PRDATA  output  DATA_W  read data; valid only while PREADY=1 and PSLVERR=0, else 0.
- PREADY  output  1  transfer completes in a cycle with PSEL & PENABLE & PREADY.
- PSLVERR  output  1  error flag; only ever high together with PREADY.

## Operation
- FSM states: IDLE and ACCESS. All of the following are registers:
  - state;
  - wait counter cnt, width clog2(WAIT_STATES+1), minimum 1;
  - err_q;
  - rdata_q.
- IDLE behaviour:
  - On an edge with PSEL=1 and PENABLE=0 (setup): load cnt ← WAIT_STATES, err_q ← (PADDR ≥ DEPTH), rdata_q ← mem[PADDR] (0 if out of range), then go to ACCESS.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol error: ignore it and stay in IDLE.
- ACCESS behaviour, evaluated in this priority order:
  1. PSEL=0: abort, go to IDLE, no write.
  2. cnt≠0: decrement cnt.
  3. cnt=0 and PENABLE=1: completion edge. If PWRITE=1 and err_q=0, write each byte lane i with PSTRB[i]=1 from PWDATA; other lanes keep their value. Go to IDLE.
  4. cnt=0 and PENABLE=0: hold.
- Outputs are combinational from registers only:
  - PREADY = (state==ACCESS) & (cnt==0);
  - PSLVERR = PREADY & err_q;
  - PRDATA = (PREADY & ~err_q & ~PWRITE) ? rdata_q : 0.
- Errored transfers: a write never modifies memory; a read returns 0.
- PWRITE, PADDR, PWDATA and PSTRB are assumed stable from setup to completion. PADDR is sampled only at setup.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (PRST=0, asynchronous): state=IDLE, cnt=0, err_q=0, rdata_q=0. Outputs PREADY=0, PSLVERR=0, PRDATA=0 immediately, without waiting for a PCLK edge.
- Reset asserted mid-transfer: the transfer is dropped and no write occurs. After release the slave accepts a fresh setup on the first PCLK edge.
- Transfer length is 2 + WAIT_STATES cycles (setup cycle plus access cycles):
  - WAIT_STATES=0: PREADY is high in the first access cycle.
  - WAIT_STATES=N: PREADY is high in access cycle N+1.
- The write takes effect at the completion edge. A read whose setup edge is the next edge returns the new data. Back-to-back transfers have no idle cycle.
- Reads latch data at the setup edge. A read is unaffected by writes from other masters (single-port memory, one transfer at a time).

## Test plan
- Reset: drive PRST=0 mid-write with WAIT_STATES=3 -> PREADY, PSLVERR and PRDATA are 0 asynchronously, and the target word is unchanged on a later read.
- Zero-wait (WAIT_STATES=0, DATA_W=32): write 0xDEADBEEF to addr 5 with PSTRB=4'hF, then read addr 5 back-to-back -> each transfer takes 2 cycles, PREADY is high in the access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
- Wait states (WAIT_STATES=3): read addr 0 -> PREADY is low for 3 access cycles and high in the 4th. PRDATA is 0 until PREADY=1, then equals the stored word.
- Byte strobes: write 0x11223344 to addr 2, then write 0xAABBCCDD with PSTRB=4'b0101 -> read returns 0x11BB33DD.
- Out of range (DEPTH=64): write 0x12345678 to addr 64, then read addr 200 -> both complete with PREADY=1 and PSLVERR=1, the read gives PRDATA=0, and a read of addr 0 is unchanged.
- Abort: drop PSEL during a wait state of a write to addr 7 -> returns to IDLE, PREADY is never asserted, mem[7] is unchanged, and the next setup completes normally.

Source files
------------

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - parametrised APB memory slave with wait states, byte strobes and range error
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRST,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W/8-1:0]   PSTRB,
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [IDX_W-1:0]    addr_q, addr_d;
  logic                mem_we;
  logic                in_range;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Address is a word index; compare one bit wider so DEPTH == 2^ADDR_W works.
  assign in_range = ({1'b0, PADDR} < (ADDR_W + 1)'(DEPTH));

  // Next-state logic: capture everything at setup, count wait states, complete or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high here is a protocol violation and is ignored.
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_STATES);
          err_d   = !in_range;
          rdata_d = in_range ? mem_q[PADDR[IDX_W-1:0]] : '0;
          addr_d  = PADDR[IDX_W-1:0];
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (PENABLE) begin
          mem_we  = PWRITE && !err_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and capture registers; async reset drops any transfer in flight.
  always_ff @(posedge PCLK or negedge PRST) begin
    if (!PRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  // Storage array, not reset; only strobed byte lanes change at the completion edge.
  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (PSTRB[i]) begin
          mem_q[addr_q][8*i +: 8] <= PWDATA[8*i +: 8];
        end
      end
    end
  end

  // Handshake outputs depend on registers only (plus PWRITE to blank read data on writes).
  always_comb begin
    PREADY  = (state_q == ACCESS) && (cnt_q == '0);
    PSLVERR = PREADY && err_q;
    PRDATA  = (PREADY && !err_q && !PWRITE) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - directed self-checking bench for apb_mem_slave
module tb_apb_mem_slave;

  logic        pclk;
  logic        prst_n;
  logic        psel0, psel3;
  logic        penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic        cur3;
  logic [31:0] prd;
  logic        rdy, err;

  int n_checks = 0;
  int n_fails  = 0;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .PCLK(pclk), .PRST(prst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .PCLK(pclk), .PRST(prst_n), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  assign prd = cur3 ? prdata3  : prdata0;
  assign rdy = cur3 ? pready3  : pready0;
  assign err = cur3 ? pslverr3 : pslverr0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // One complete transfer; leaves the bus right after the completion edge so
  // a following call is back-to-back.
  task automatic xfer(input bit s3, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic [31:0] exp_rd, input bit exp_err, input string tag);
    int  waits;
    bit  done;
    cur3 = s3;
    psel0 = !s3; psel3 = s3; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge pclk);
      if (rdy) begin
        done = 1;
      end else begin
        chk({tag, " wait prdata"}, prd, 32'h0);
        chk({tag, " wait pslverr"}, {31'h0, err}, 32'h0);
        waits++;
        @(posedge pclk); #1;
      end
    end
    chk({tag, " completed"}, {31'h0, done}, 32'h1);
    chk({tag, " wait cycles"}, 32'(waits), s3 ? 32'd3 : 32'd0);
    chk({tag, " pslverr"}, {31'h0, err}, {31'h0, exp_err});
    chk({tag, " prdata"}, prd, exp_rd);
    @(posedge pclk); #1;
  endtask

  initial begin
    cur3 = 1'b0;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    prst_n = 1'b0;
    #1;
    chk("reset pready0",  {31'h0, pready0},  32'h0);
    chk("reset pslverr0", {31'h0, pslverr0}, 32'h0);
    chk("reset prdata0",  prdata0,           32'h0);
    chk("reset pready3",  {31'h0, pready3},  32'h0);
    chk("reset prdata3",  prdata3,           32'h0);
    repeat (2) @(posedge pclk);
    #1 prst_n = 1'b1;
    @(posedge pclk); #1;

    // Zero wait states: write then read back-to-back
    xfer(0, 1, 8'd5, 32'hDEADBEEF, 4'hF, 32'h0,        0, "ws0 wr5");
    xfer(0, 0, 8'd5, 32'h0,        4'h0, 32'hDEADBEEF, 0, "ws0 rd5");
    idle();

    // Byte strobes
    xfer(0, 1, 8'd2, 32'h11223344, 4'hF,    32'h0,        0, "strb wr full");
    xfer(0, 1, 8'd2, 32'hAABBCCDD, 4'b0101, 32'h0,        0, "strb wr part");
    xfer(0, 0, 8'd2, 32'h0,        4'h0,    32'h11BB33DD, 0, "strb rd");
    idle();

    // Three wait states: read of a known word
    xfer(1, 1, 8'd0, 32'hCAFE0001, 4'hF, 32'h0,        0, "ws3 wr0");
    xfer(1, 0, 8'd0, 32'h0,        4'h0, 32'hCAFE0001, 0, "ws3 rd0");
    idle();

    // Out of range
    xfer(1, 1, 8'd64,  32'h12345678, 4'hF, 32'h0,        1, "oor wr64");
    xfer(1, 0, 8'd200, 32'h0,        4'h0, 32'h0,        1, "oor rd200");
    xfer(1, 0, 8'd0,   32'h0,        4'h0, 32'hCAFE0001, 0, "oor rd0");
    idle();

    // Abort during a wait state
    xfer(1, 1, 8'd7, 32'h07070707, 4'hF, 32'h0, 0, "abort pre wr7");
    idle();
    cur3 = 1'b1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7;
    pwdata = 32'hFFFF0000; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("abort wait pready", {31'h0, pready3}, 32'h0);
    @(posedge pclk); #1;
    psel3 = 1'b0; penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      chk("abort pready low", {31'h0, pready3}, 32'h0);
    end
    @(posedge pclk); #1;
    xfer(1, 0, 8'd7, 32'h0, 4'h0, 32'h07070707, 0, "abort rd7");
    idle();

    // Async reset in the completion cycle of a write
    xfer(1, 1, 8'd9, 32'h0BADF00D, 4'hF, 32'h0, 0, "rst pre wr9");
    idle();
    cur3 = 1'b1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst ready before", {31'h0, pready3}, 32'h1);
    #1 prst_n = 1'b0;
    #1;
    chk("rst async pready",  {31'h0, pready3},  32'h0);
    chk("rst async pslverr", {31'h0, pslverr3}, 32'h0);
    chk("rst async prdata",  prdata3,           32'h0);
    psel3 = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    prst_n = 1'b1;
    xfer(1, 0, 8'd9, 32'h0, 4'h0, 32'h0BADF00D, 0, "rst rd9");
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
